// File: rtl/ldl_cos_age_v1.sv
`default_nettype none
// ============================================================================
//  Module   : ldl_cos_age_v1
//  Purpose  : Anti-starvation front end for a class-of-service round-robin
//             arbiter. Each requester that waits without a grant has its
//             effective COS raised by one level every AGE_LIMIT waiting
//             cycles, saturating at COS_MAX. A grant (ack), a withdrawn
//             request or reset clears the accumulated boost.
//
//  Ports    : clk      - sole clock, rising-edge active
//             rst      - synchronous, active-high reset
//             req      - raw request per requester
//             icos     - native COS per requester
//             ack      - grant-accepted strobe from the arbiter (one-hot/zero)
//             ocos     - effective COS = min(icos + boost, COS_MAX)
//             aged     - per-requester flag, high while boost is non-zero
//             promote  - registered pulse, one cycle after any promotion
//
//  Revision : 1.0  initial release
// ============================================================================
module ldl_cos_age_v1 #(
    parameter int BIN_WIDTH = 3,
    parameter int COS_WIDTH = 2,
    parameter int AGE_WIDTH = 4,
    parameter int AGE_LIMIT = 10,
    parameter int REQ_WIDTH = 1 << BIN_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQ_WIDTH-1:0]                req,
    input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] icos,
    input  logic [REQ_WIDTH-1:0]                ack,
    output logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] ocos,
    output logic [REQ_WIDTH-1:0]                aged,
    output logic                                promote
);

    // Highest class of service; boost stops accumulating once reached.
    localparam logic [COS_WIDTH-1:0] c_cos_max  = {COS_WIDTH{1'b1}};

    // Counter value on which a waiting requester gets promoted. AGE_LIMIT
    // may equal 2**AGE_WIDTH, so the terminal count is AGE_LIMIT-1, which
    // always fits in AGE_WIDTH bits.
    localparam logic [AGE_WIDTH-1:0] c_age_last = AGE_WIDTH'(AGE_LIMIT - 1);

    // ------------------------------------------------------------------------
    // Parameter legality: a zero limit or one beyond the counter range cannot
    // be represented and is rejected at elaboration.
    // ------------------------------------------------------------------------
    if ((AGE_LIMIT < 1) || (AGE_LIMIT > (1 << AGE_WIDTH))) begin : g_bad_age_limit
        $error("ldl_cos_age_v1: AGE_LIMIT %0d outside 1..%0d",
               AGE_LIMIT, (1 << AGE_WIDTH));
    end

    logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] w_eff;   // saturated effective COS
    logic [REQ_WIDTH-1:0]                w_fire;  // promotion happening this cycle
    logic                                r_promote;

    // ------------------------------------------------------------------------
    // Per-requester ageing slice. Requesters are fully independent; only the
    // promote pulse combines them.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < REQ_WIDTH; gi++) begin : g_req
        logic [AGE_WIDTH-1:0] r_cnt;     // cycles waited since last promotion
        logic [COS_WIDTH-1:0] r_boost;   // levels gained while waiting
        logic [COS_WIDTH:0]   w_sum;     // one extra bit to catch overflow
        logic                 w_at_max;
        logic                 w_clear;

        // Only icos is live here; boost is a register, so the arbiter loop
        // (ocos -> arbiter -> ack -> here) never closes combinationally.
        assign w_sum      = {1'b0, icos[gi]} + {1'b0, r_boost};
        assign w_eff[gi]  = w_sum[COS_WIDTH] ? c_cos_max : w_sum[COS_WIDTH-1:0];
        assign w_at_max   = (w_eff[gi] == c_cos_max);

        // Reset, a withdrawn request and a grant all drop every bit of credit.
        // An ack without a request falls under the withdrawn case.
        assign w_clear    = rst | ~req[gi] | ack[gi];

        // Promotion fires only for a live, ungranted wait that has not yet hit
        // the ceiling and has just completed AGE_LIMIT waiting cycles.
        assign w_fire[gi] = ~w_clear & ~w_at_max & (r_cnt == c_age_last);

        always_ff @(posedge clk) begin
            if (w_clear) begin
                r_cnt   <= '0;
                r_boost <= '0;
            end else if (w_at_max) begin
                // Already at the ceiling (possibly because icos moved up
                // mid-wait): freeze counting but keep the boost so that a
                // later drop of icos still sees the credit earned so far.
                r_cnt   <= '0;
            end else if (r_cnt == c_age_last) begin
                r_cnt   <= '0;
                r_boost <= r_boost + COS_WIDTH'(1);
            end else begin
                r_cnt   <= r_cnt + AGE_WIDTH'(1);
            end
        end

        assign aged[gi] = |r_boost;
    end

    // ------------------------------------------------------------------------
    // Single pulse regardless of how many requesters promoted together.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_promote <= 1'b0;
        end else begin
            r_promote <= |w_fire;
        end
    end

    assign ocos    = w_eff;
    assign promote = r_promote;

endmodule
`default_nettype wire

// File: tb/tb_ldl_cos_age_v1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldl_cos_age_v1
//  Purpose  : Self-checking bench for ldl_cos_age_v1. Directed waits with
//             constant expectations, then randomized traffic against an
//             integer reference model of the ageing rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ldl_cos_age_v1;

    localparam int BW   = 3;
    localparam int CW   = 2;
    localparam int AW   = 4;
    localparam int AL   = 10;
    localparam int N    = 1 << BW;
    localparam int CMAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0][CW-1:0] icos;
    logic [N-1:0]         ack;
    logic [N-1:0][CW-1:0] ocos;
    logic [N-1:0]         aged;
    logic                 promote;

    ldl_cos_age_v1 #(
        .BIN_WIDTH (BW),
        .COS_WIDTH (CW),
        .AGE_WIDTH (AW),
        .AGE_LIMIT (AL)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .icos    (icos),
        .ack     (ack),
        .ocos    (ocos),
        .aged    (aged),
        .promote (promote)
    );

    always #5 clk = ~clk;

    // Reference model: waiting time and earned levels as plain integers.
    int m_wait  [N];
    int m_level [N];
    int m_prom;

    int n_vec;
    int n_err;
    bit chk_en;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff_of(input int i);
        int s;
        s = int'(icos[i]) + m_level[i];
        return (s > CMAX) ? CMAX : s;
    endfunction

    // Apply the ageing rules for one clock edge using the inputs of the cycle.
    task automatic model_step();
        int fired;
        fired = 0;
        for (int i = 0; i < N; i++) begin
            if (rst || !req[i] || ack[i]) begin
                m_wait[i]  = 0;
                m_level[i] = 0;
            end else if (eff_of(i) == CMAX) begin
                m_wait[i]  = 0;
            end else if (m_wait[i] == AL - 1) begin
                m_wait[i]  = 0;
                m_level[i] = m_level[i] + 1;
                fired      = 1;
            end else begin
                m_wait[i]  = m_wait[i] + 1;
            end
        end
        m_prom = fired;
    endtask

    // Inputs are set at posedge+1; outputs are sampled at the negedge, then
    // the model and DUT both advance on the next posedge. Optional constant
    // expectations for requester 0 are checked when non-negative.
    task automatic tick(input int d_ocos0 = -1, input int d_prom = -1, input int d_aged0 = -1);
        #4;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("ocos[%0d]", i), 32'(ocos[i]), eff_of(i));
                check($sformatf("aged[%0d]", i), 32'(aged[i]), (m_level[i] != 0) ? 1 : 0);
            end
            check("promote", 32'(promote), m_prom);
            if (d_ocos0 >= 0) check("dir_ocos0", 32'(ocos[0]), d_ocos0);
            if (d_prom  >= 0) check("dir_promote", 32'(promote), d_prom);
            if (d_aged0 >= 0) check("dir_aged0", 32'(aged[0]), d_aged0);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int k;
        n_vec  = 0;
        n_err  = 0;
        chk_en = 0;
        m_prom = 0;
        for (int i = 0; i < N; i++) begin
            m_wait[i]  = 0;
            m_level[i] = 0;
        end

        // Reset with everything idle.
        rst  = 1'b1;
        req  = '0;
        ack  = '0;
        icos = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk_en = 1;

        // Reset state check (still in reset, icos non-zero to see pass-through).
        icos[0] = 2'd2;
        tick(2, 0, 0);
        icos[0] = 2'd0;
        rst     = 1'b0;

        // Single long wait on requester 0 from icos=0.
        req = 8'h01;
        for (k = 0; k < 35; k++) begin
            tick((k / AL > CMAX) ? CMAX : k / AL,
                 (k == 10 || k == 20 || k == 30) ? 1 : 0,
                 (k >= 10) ? 1 : 0);
        end

        // Mid-wait reset: boost lost at once, next promotion 10 cycles later.
        rst = 1'b1;
        tick(3, 0, 1);
        rst = 1'b0;
        for (k = 0; k < 12; k++) begin
            tick((k >= 10) ? 1 : 0, (k == 10) ? 1 : 0, (k >= 10) ? 1 : 0);
        end

        // Ack at cycle 15 of a fresh wait: clears at 16, next promotion at 26.
        req = 8'h00;
        tick();
        req = 8'h01;
        for (k = 0; k < 28; k++) begin
            ack = (k == 15) ? 8'h01 : 8'h00;
            tick((k >= 10 && k <= 15) || k >= 26 ? 1 : 0,
                 (k == 10 || k == 26) ? 1 : 0,
                 (k >= 10 && k <= 15) || k >= 26 ? 1 : 0);
        end
        ack = '0;

        // Two requesters with icos=1 waiting together, plus requester 3 whose
        // icos jumps to the ceiling mid-wait.
        req     = 8'h00;
        tick();
        icos[1] = 2'd1;
        icos[6] = 2'd1;
        icos[3] = 2'd2;
        req     = 8'b0100_1010;
        for (k = 0; k < 14; k++) begin
            if (k == 5) icos[3] = 2'd3;
            tick(-1, (k == 10) ? 1 : 0, -1);
        end

        // Randomized traffic against the reference model.
        req  = N'($urandom);
        for (int i = 0; i < N; i++) icos[i] = CW'($urandom);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 19) == 0) req[i]  = ~req[i];
                if ($urandom_range(0, 39) == 0) icos[i] = CW'($urandom);
            end
            ack = '0;
            if ($urandom_range(0, 9) == 0) ack[$urandom_range(0, N - 1)] = 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldl_cos_age_v1.md
# LDL_cos_age_v1

Anti-starvation front end for the class-of-service round-robin arbiter. It sits directly upstream of the arbiter and tracks how long each requester has waited without a grant. Each time the wait reaches a programmable limit, it raises that requester's effective class of service by one level. Its `ocos` drives the arbiter's per-requester COS inputs, and the arbiter's `ack` returns here to clear the ageing state.

## Interface
- `BIN_WIDTH`, 3, log2 of requester count.
- `COS_WIDTH`, 2, COS field width; 0 is lowest, `2**COS_WIDTH-1` (COS_MAX) is highest.
- `AGE_WIDTH`, 4, width of each per-requester wait counter.
- `AGE_LIMIT`, 10, waiting cycles per one-level promotion. Legal range 1..`2**AGE_WIDTH`; out-of-range values are an elaboration error.
- `REQ_WIDTH`, `1<<BIN_WIDTH`, requester count.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  `REQ_WIDTH`  raw request per requester; also routed to the arbiter unchanged by the parent.
- `icos`  in  `[REQ_WIDTH][COS_WIDTH]`  native COS per requester.
- `ack`  in  `REQ_WIDTH`  grant-accepted strobe from the arbiter; at most one bit set per cycle.
- `ocos`  out  `[REQ_WIDTH][COS_WIDTH]`  effective COS, equal to `min(icos[i]+boost[i], COS_MAX)`.
- `aged`  out  `REQ_WIDTH`  bit i high when `boost[i] != 0`.
- `promote`  out  1  registered pulse, high for one cycle after any requester was promoted.

## Operation
- Per-requester state:
  - `cnt[i]`, `AGE_WIDTH` bits.
  - `boost[i]`, `COS_WIDTH` bits.
- Effective COS `eff[i] = min(icos[i]+boost[i], COS_MAX)`:
  - Computed at `COS_WIDTH+1` bits, then saturated.
  - Purely combinational from live `icos` and registered `boost`.
- Next-state per requester, in priority order:
  1. `rst`: `cnt=0`, `boost=0`.
  2. `!req[i]`: `cnt=0`, `boost=0` (withdrawn request loses all credit).
  3. `req[i] & ack[i]`: `cnt=0`, `boost=0` (served).
  4. `req[i] & !ack[i] & eff[i]==COS_MAX`: `cnt=0`, `boost` holds (already at ceiling, no counting).
  5. `req[i] & !ack[i] & cnt[i]==AGE_LIMIT-1`: `cnt=0`, `boost=boost+1`.
  6. Otherwise: `cnt=cnt+1`.
- `ack[i]` without `req[i]` is treated as rule 2 and does not assert `promote`.
- A change of `icos[i]` during a wait keeps `cnt` and `boost`. The new `eff` uses the new `icos` and is re-saturated.
  - If the new `eff` hits COS_MAX, rule 4 applies from that cycle.
- `boost` never exceeds `COS_MAX`; rules 4/5 guarantee no wrap.
- `promote` is registered: it is set in cycle n+1 when rule 5 fired for any i in cycle n.
- Requesters are independent. Simultaneous promotions of several requesters in one cycle are allowed and produce a single `promote` pulse.

## Timing
- Reset values:
  - `ocos = icos`, `aged = 0`, `promote = 0`.
  - All counters 0.
  - Outputs are valid in the first cycle after `rst` deasserts.
- Let cycle 0 be the first cycle `req[i]` is high with `ack[i]` low. Then `ocos[i]=icos[i]` in cycles 0..`AGE_LIMIT-1`.
- `ocos[i]=icos[i]+1` from cycle `AGE_LIMIT`, and `+k` from cycle `k*AGE_LIMIT`, until COS_MAX.
- `AGE_LIMIT=1`: promotion every waiting cycle.
- `ack[i]` in cycle n: `ocos[i]=icos[i]` and `aged[i]=0` from cycle n+1.
- No combinational path from `ack` or `req` to `ocos`. The only combinational path is `icos` to `ocos`, so the arbiter loop has no comb cycle.
- `rst` mid-wait clears all boosts at the next edge, regardless of `req`/`ack` that cycle.

## Test plan
- Reset then `req=8'h01`, `icos[0]=0`, `ack=0`, defaults -> `ocos[0]` is 0 for cycles 0–9, 1 for 10–19, 2 for 20–29, then 3 held. `promote` pulses at cycles 10, 20, 30 only. `aged[0]=1` from cycle 10.
- Same wait with `ack[0]` pulsed at cycle 15 -> `ocos[0]=0` and `aged[0]=0` at cycle 16. The next promotion lands at cycle 26.
- `req[2]` dropped at cycle 12 and re-raised at cycle 13 -> boost lost. `ocos[2]` returns to `icos[2]`, and the next promotion lands at cycle 23.
- `icos[3]=2` waiting; at cycle 5 `icos[3]` changes to 3 -> `ocos[3]=3` immediately. No counting and no `promote` for requester 3 after that.
- Requesters 1 and 6 raise `req` in the same cycle with `icos=1` and no ack -> both promote at cycle 10. `promote` is a single one-cycle pulse at cycle 10.
- `rst` asserted at cycle 17 with requester 0 boosted -> from cycle 18, `ocos[0]=icos[0]`, `aged=0`, `promote=0`. Counting restarts and the next promotion lands 10 cycles after `rst` falls.
